// File: rtl/level_sequencer_pkg.sv
// level_sequencer_pkg: shared game state encoding and default level geometry
package level_sequencer_pkg;
  typedef enum logic [1:0] {PLAY, CLEAR, WIN} state_t;
  localparam int DEF_GOAL_X = 481;
  localparam int DEF_GOAL_Y = 108;
  localparam int DEF_NUM_LEVELS = 8;
  localparam int DEF_LEVEL_W = 4;
endpackage

// File: rtl/level_sequencer_frame_delay_counter.sv
// frame_delay_counter: loadable down-counter advanced by frame_tick with zero flag
module frame_delay_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero
);
  logic [W-1:0] cnt;
  // load wins over tick so a tick on the load cycle is never counted
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (tick && cnt != '0) cnt <= cnt - W'(1);
  end
  assign zero = (cnt == '0);
endmodule

// File: rtl/level_sequencer.sv
// level_sequencer: goal detection, timed level transition, bonus and win handling
module level_sequencer
  import level_sequencer_pkg::*;
#(
  parameter int POS_W         = 12,
  parameter int PTS_W         = 11,
  parameter int LEVEL_W       = DEF_LEVEL_W,
  parameter int NUM_LEVELS    = DEF_NUM_LEVELS,
  parameter int GOAL_X        = DEF_GOAL_X,
  parameter int GOAL_Y        = DEF_GOAL_Y,
  parameter int PTS_PER_LEVEL = 0,
  parameter int TRANS_FRAMES  = 60,
  parameter int BONUS_BASE    = 10,
  parameter bit WRAP          = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               restart,
  input  logic [PTS_W-1:0]   points,
  input  logic [POS_W-1:0]   hero_x_pos,
  input  logic [POS_W-1:0]   hero_y_pos,
  output logic [LEVEL_W-1:0] level,
  output logic               hero_rst,
  output logic               level_done,
  output logic               bonus_valid,
  output logic [PTS_W-1:0]   bonus_pts,
  output logic               game_won
);
  localparam int CW = (TRANS_FRAMES > 1) ? $clog2(TRANS_FRAMES) : 1;
  localparam int NW = PTS_W + LEVEL_W + 1;
  localparam int PMAX = 2**PTS_W - 1;
  state_t state, state_n;
  logic armed, armed_n;
  logic [LEVEL_W-1:0] level_n;
  logic hero_rst_n, level_done_n, bonus_valid_n, game_won_n;
  logic [PTS_W-1:0] bonus_pts_n, bonus_sat;
  logic load, zero, at_goal, unlock, accept, last;
  logic [CW-1:0] load_val;
  logic [NW-1:0] need;
  logic [31:0] bonus_raw;
  assign at_goal   = (hero_x_pos == POS_W'(GOAL_X)) && (hero_y_pos == POS_W'(GOAL_Y));
  assign need      = NW'(PTS_PER_LEVEL) * (NW'(level) + NW'(1));
  assign unlock    = NW'(points) >= need;
  assign accept    = at_goal && armed && unlock;
  assign last      = (level == LEVEL_W'(NUM_LEVELS - 1));
  assign bonus_raw = 32'(BONUS_BASE) * (32'(level) + 32'd1);
  assign bonus_sat = (bonus_raw > 32'(PMAX)) ? PTS_W'(PMAX) : PTS_W'(bonus_raw);
  frame_delay_counter #(.W(CW)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .tick     (frame_tick && state == CLEAR),
    .zero     (zero)
  );
  // register all state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PLAY;
      level       <= '0;
      armed       <= 1'b0;
      hero_rst    <= 1'b0;
      level_done  <= 1'b0;
      bonus_valid <= 1'b0;
      bonus_pts   <= '0;
      game_won    <= 1'b0;
    end else begin
      state       <= state_n;
      level       <= level_n;
      armed       <= armed_n;
      hero_rst    <= hero_rst_n;
      level_done  <= level_done_n;
      bonus_valid <= bonus_valid_n;
      bonus_pts   <= bonus_pts_n;
      game_won    <= game_won_n;
    end
  end
  // next-state: restart overrides everything, then per-state goal/transition rules
  always_comb begin
    state_n       = state;
    level_n       = level;
    armed_n       = armed;
    hero_rst_n    = 1'b0;
    level_done_n  = 1'b0;
    bonus_valid_n = 1'b0;
    bonus_pts_n   = bonus_pts;
    game_won_n    = 1'b0;
    load          = 1'b0;
    load_val      = '0;
    if (restart) begin
      state_n    = PLAY;
      level_n    = '0;
      armed_n    = 1'b0;
      hero_rst_n = 1'b1;
      load       = 1'b1;
    end else begin
      case (state)
        PLAY: begin
          armed_n = accept ? 1'b0 : (armed || !at_goal);
          level_done_n = accept;
          hero_rst_n = accept;
          state_n = accept ? CLEAR : PLAY;
          load = accept;
          load_val = CW'(TRANS_FRAMES - 1);
        end
        CLEAR: begin
          hero_rst_n = 1'b1;
          if (frame_tick && zero) begin
            bonus_valid_n = 1'b1;
            bonus_pts_n = bonus_sat;
            if (last && !WRAP) begin
              state_n = WIN;
              game_won_n = 1'b1;
            end else begin
              state_n = PLAY;
              level_n = last ? '0 : level + LEVEL_W'(1);
              hero_rst_n = 1'b0;
            end
          end
        end
        default: begin
          hero_rst_n = 1'b1;
          game_won_n = 1'b1;
        end
      endcase
    end
  end
endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
- Parametrised successor to the per-level goal detector.
- Watches hero position and score, then advances the level through a timed transition with the hero held in reset.
- Supports a configurable level count with either wrap-around or a final WIN state.
- Issues a one-shot level-clear bonus to the score unit; sits between the hero controller, score counter and map/ROM level select.

Parameters:
POS_W, 12, width of hero_x_pos/hero_y_pos
PTS_W, 11, width of points and bonus_pts
LEVEL_W, 4, width of level output
NUM_LEVELS, 8, number of levels (2..2**LEVEL_W)
GOAL_X, 481, goal x coordinate
GOAL_Y, 108, goal y coordinate
PTS_PER_LEVEL, 0, points required per level index to unlock goal (0 = no gate)
TRANS_FRAMES, 60, frame_ticks the hero is held in reset during transition (>=1)
BONUS_BASE, 10, bonus per cleared level, multiplied by (cleared level + 1)
WRAP, 0, 1: after last level return to level 0; 0: enter WIN

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_tick  in  1  one-cycle pulse per video frame
restart  in  1  one-cycle pulse, restart game from level 0
points  in  PTS_W  current score
hero_x_pos  in  POS_W  hero x position
hero_y_pos  in  POS_W  hero y position
level  out  LEVEL_W  current level index
hero_rst  out  1  hold hero at spawn
level_done  out  1  one-cycle pulse on goal acceptance
bonus_valid  out  1  one-cycle pulse, add bonus_pts to score
bonus_pts  out  PTS_W  bonus value, valid with bonus_valid
game_won  out  1  high while in WIN

Behaviour:
- Single clock, clk. Reset is synchronous and active-high, rst. All outputs are registered.
- Reset values:
  - level=0, hero_rst=0, level_done=0, bonus_valid=0, bonus_pts=0, game_won=0.
  - state=PLAY, frame counter=0, armed=0.
- at_goal = (hero_x_pos==GOAL_X) && (hero_y_pos==GOAL_Y).
- armed: set in PLAY on any cycle with !at_goal; cleared on goal acceptance, restart and reset. This prevents multi-cycle or spawn-on-goal re-triggering.
- unlock = points >= PTS_PER_LEVEL*(level+1). Compute at PTS_W+LEVEL_W+1 bits; no truncation before compare.
- PLAY:
  - Goal is accepted when at_goal && armed && unlock.
  - Next cycle: level_done=1 for one cycle, hero_rst=1, armed=0, counter=TRANS_FRAMES-1, state=CLEAR.
- CLEAR:
  - hero_rst held 1.
  - On each frame_tick with counter!=0, decrement the counter.
  - On frame_tick with counter==0:
    - bonus_valid=1 for one cycle, bonus_pts=BONUS_BASE*(level+1) saturated to 2**PTS_W-1.
    - If level==NUM_LEVELS-1 and WRAP=0: state=WIN, level unchanged, hero_rst stays 1.
    - Else: level = (level==NUM_LEVELS-1) ? 0 : level+1; state=PLAY; hero_rst=0 from the same edge.
  - Position and points are ignored in CLEAR.
- WIN:
  - game_won=1, hero_rst=1, level frozen, goal and frame_tick ignored.
- restart (any state, including mid-CLEAR):
  - Priority over all other events in the same cycle.
  - Next cycle: level=0, state=PLAY, armed=0, counter=0, game_won=0.
  - hero_rst=1 for exactly one cycle, then 0; pending bonus dropped.
- Goal acceptance and frame_tick in the same cycle in PLAY: the tick is not counted; the transition lasts a full TRANS_FRAMES ticks.
- Latency:
  - Goal acceptance to level_done: 1 cycle.
  - Final tick to level change: 1 cycle.
- Total hero hold time: exactly TRANS_FRAMES frame_ticks after acceptance.
- bonus_pts holds its last value between pulses.

Decomposition:
- Shared game package holds:
  - state encoding localparams (PLAY, CLEAR, WIN);
  - default GOAL_X/GOAL_Y;
  - NUM_LEVELS;
  - LEVEL_W.
- Sub-module frame_delay_counter: loadable down-counter advanced by frame_tick, with a zero flag. Reused by the respawn and bonus timers.

Test Plan:
- Reset, hero at (481,108) from the first cycle with points=0 → no level_done; level stays 0 until the hero leaves and returns.
- Hero enters goal and stays 10 cycles, TRANS_FRAMES=3 → a single level_done pulse; hero_rst high through 3 frame_ticks; then level=1, bonus_valid pulse with bonus_pts=10, hero_rst=0.
- PTS_PER_LEVEL=50, level=1, points=99 at goal → ignored; points=100 → accepted.
- NUM_LEVELS=4, WRAP=0, clear level 3 → game_won=1, level=3, hero_rst=1; restart → level=0, game_won=0, one-cycle hero_rst pulse.
- WRAP=1, clear level NUM_LEVELS-1 → level=0, state PLAY, bonus_pts=BONUS_BASE*NUM_LEVELS.
- restart asserted mid-CLEAR together with the final frame_tick → no bonus_valid, level=0, PLAY; later rst mid-CLEAR → all outputs at reset values on the next edge.
